// File: rtl/mmu_tl_arb.sv
// mmu_tl_arb: arbitrates the page walker (m0) and LSU (m1) onto one single-beat
// TileLink-UL port with at most one transaction outstanding downstream.
module mmu_tl_arb #(
  parameter int HPW_PRIO = 1
) (
  input  logic        cpu_clk_i,
  input  logic        cpu_rst_i,
  input  logic [2:0]  m0_a_opcode,
  input  logic [2:0]  m0_a_param,
  input  logic [3:0]  m0_a_size,
  input  logic [31:0] m0_a_address,
  input  logic [3:0]  m0_a_mask,
  input  logic [31:0] m0_a_data,
  input  logic        m0_a_corrupt,
  input  logic        m0_a_valid,
  output logic        m0_a_ready,
  output logic [2:0]  m0_d_opcode,
  output logic [1:0]  m0_d_param,
  output logic [3:0]  m0_d_size,
  output logic        m0_d_denied,
  output logic [31:0] m0_d_data,
  output logic        m0_d_corrupt,
  output logic        m0_d_valid,
  input  logic        m0_d_ready,
  input  logic [2:0]  m1_a_opcode,
  input  logic [2:0]  m1_a_param,
  input  logic [3:0]  m1_a_size,
  input  logic [31:0] m1_a_address,
  input  logic [3:0]  m1_a_mask,
  input  logic [31:0] m1_a_data,
  input  logic        m1_a_corrupt,
  input  logic        m1_a_valid,
  output logic        m1_a_ready,
  output logic [2:0]  m1_d_opcode,
  output logic [1:0]  m1_d_param,
  output logic [3:0]  m1_d_size,
  output logic        m1_d_denied,
  output logic [31:0] m1_d_data,
  output logic        m1_d_corrupt,
  output logic        m1_d_valid,
  input  logic        m1_d_ready,
  output logic [2:0]  s_a_opcode,
  output logic [2:0]  s_a_param,
  output logic [3:0]  s_a_size,
  output logic [31:0] s_a_address,
  output logic [3:0]  s_a_mask,
  output logic [31:0] s_a_data,
  output logic        s_a_corrupt,
  output logic        s_a_valid,
  input  logic        s_a_ready,
  input  logic [2:0]  s_d_opcode,
  input  logic [1:0]  s_d_param,
  input  logic [3:0]  s_d_size,
  input  logic        s_d_denied,
  input  logic [31:0] s_d_data,
  input  logic        s_d_corrupt,
  input  logic        s_d_valid,
  output logic        s_d_ready,
  output logic        busy_o
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  state_t state, state_nx;
  logic owner, last, win, grant;
  // win=1 selects m1; in round-robin mode a tie goes to whoever was not granted last
  assign win = (HPW_PRIO != 0) ? !m0_a_valid : (m0_a_valid && m1_a_valid) ? !last : m1_a_valid;
  assign grant = state == IDLE && (m0_a_valid || m1_a_valid) && !cpu_rst_i;
  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i)
    if (cpu_rst_i) state <= IDLE;
    else           state <= state_nx;
  always_comb
    state_nx = grant ? REQ :
               (state == REQ && s_a_ready) ? RESP :
               (state == RESP && s_d_valid && s_d_ready) ? IDLE : state;
  always_comb begin
    m0_a_ready = grant && !win;
    m1_a_ready = grant && win;
    s_a_valid  = state == REQ;
    s_d_ready  = state == RESP && (owner ? m1_d_ready : m0_d_ready);
    m0_d_valid = state == RESP && !owner && s_d_valid;
    m1_d_valid = state == RESP && owner && s_d_valid;
    busy_o     = state != IDLE;
  end
  always_ff @(posedge cpu_clk_i or posedge cpu_rst_i)
    if (cpu_rst_i) begin
      owner <= 1'b0;
      last  <= 1'b1;
      {s_a_opcode, s_a_param, s_a_size, s_a_address, s_a_mask, s_a_data, s_a_corrupt} <= '0;
    end else if (grant) begin
      owner <= win;
      last  <= win;
      {s_a_opcode, s_a_param, s_a_size, s_a_address, s_a_mask, s_a_data, s_a_corrupt} <= win ?
        {m1_a_opcode, m1_a_param, m1_a_size, m1_a_address, m1_a_mask, m1_a_data, m1_a_corrupt} :
        {m0_a_opcode, m0_a_param, m0_a_size, m0_a_address, m0_a_mask, m0_a_data, m0_a_corrupt};
    end
  // D channel fields go to both masters; only d_valid is steered
  assign {m0_d_opcode, m0_d_param, m0_d_size, m0_d_denied, m0_d_data, m0_d_corrupt} =
         {s_d_opcode, s_d_param, s_d_size, s_d_denied, s_d_data, s_d_corrupt};
  assign {m1_d_opcode, m1_d_param, m1_d_size, m1_d_denied, m1_d_data, m1_d_corrupt} =
         {s_d_opcode, s_d_param, s_d_size, s_d_denied, s_d_data, s_d_corrupt};
endmodule

// File: tb/tb_mmu_tl_arb.sv
// tb_mmu_tl_arb: runs a round-robin (instance 0) and a fixed-priority (instance 1)
// arbiter in lockstep against a transaction-level reference model.
module tb_mmu_tl_arb;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  logic [78:0] a_pk [2][2];
  logic        m_a_valid [2][2];
  logic        m_d_ready [2][2];
  wire         m_a_ready [2][2];
  wire         m_d_valid [2][2];
  wire  [2:0]  m_d_opcode [2][2];
  wire  [1:0]  m_d_param [2][2];
  wire  [3:0]  m_d_size [2][2];
  wire         m_d_denied [2][2];
  wire  [31:0] m_d_data [2][2];
  wire         m_d_corrupt [2][2];
  wire  [2:0]  s_a_opcode [2];
  wire  [2:0]  s_a_param [2];
  wire  [3:0]  s_a_size [2];
  wire  [31:0] s_a_address [2];
  wire  [3:0]  s_a_mask [2];
  wire  [31:0] s_a_data [2];
  wire         s_a_corrupt [2];
  wire         s_a_valid [2];
  wire         s_d_ready [2];
  wire         busy [2];
  logic        s_a_ready [2];
  logic        s_d_valid [2];
  logic [42:0] d_pk [2];
  for (genvar g = 0; g < 2; g++) begin : g_dut
    mmu_tl_arb #(.HPW_PRIO(g)) u_dut (
      .cpu_clk_i(clk), .cpu_rst_i(rst),
      .m0_a_opcode(a_pk[g][0][78:76]), .m0_a_param(a_pk[g][0][75:73]), .m0_a_size(a_pk[g][0][72:69]),
      .m0_a_address(a_pk[g][0][68:37]), .m0_a_mask(a_pk[g][0][36:33]), .m0_a_data(a_pk[g][0][32:1]),
      .m0_a_corrupt(a_pk[g][0][0]), .m0_a_valid(m_a_valid[g][0]), .m0_a_ready(m_a_ready[g][0]),
      .m0_d_opcode(m_d_opcode[g][0]), .m0_d_param(m_d_param[g][0]), .m0_d_size(m_d_size[g][0]),
      .m0_d_denied(m_d_denied[g][0]), .m0_d_data(m_d_data[g][0]), .m0_d_corrupt(m_d_corrupt[g][0]),
      .m0_d_valid(m_d_valid[g][0]), .m0_d_ready(m_d_ready[g][0]),
      .m1_a_opcode(a_pk[g][1][78:76]), .m1_a_param(a_pk[g][1][75:73]), .m1_a_size(a_pk[g][1][72:69]),
      .m1_a_address(a_pk[g][1][68:37]), .m1_a_mask(a_pk[g][1][36:33]), .m1_a_data(a_pk[g][1][32:1]),
      .m1_a_corrupt(a_pk[g][1][0]), .m1_a_valid(m_a_valid[g][1]), .m1_a_ready(m_a_ready[g][1]),
      .m1_d_opcode(m_d_opcode[g][1]), .m1_d_param(m_d_param[g][1]), .m1_d_size(m_d_size[g][1]),
      .m1_d_denied(m_d_denied[g][1]), .m1_d_data(m_d_data[g][1]), .m1_d_corrupt(m_d_corrupt[g][1]),
      .m1_d_valid(m_d_valid[g][1]), .m1_d_ready(m_d_ready[g][1]),
      .s_a_opcode(s_a_opcode[g]), .s_a_param(s_a_param[g]), .s_a_size(s_a_size[g]),
      .s_a_address(s_a_address[g]), .s_a_mask(s_a_mask[g]), .s_a_data(s_a_data[g]),
      .s_a_corrupt(s_a_corrupt[g]), .s_a_valid(s_a_valid[g]), .s_a_ready(s_a_ready[g]),
      .s_d_opcode(d_pk[g][42:40]), .s_d_param(d_pk[g][39:38]), .s_d_size(d_pk[g][37:34]),
      .s_d_denied(d_pk[g][33]), .s_d_data(d_pk[g][32:1]), .s_d_corrupt(d_pk[g][0]),
      .s_d_valid(s_d_valid[g]), .s_d_ready(s_d_ready[g]), .busy_o(busy[g])
    );
  end
  // reference model: phase 0 = nothing in flight, 1 = request awaiting acceptance, 2 = awaiting response
  int phase [2], owner [2], last_w [2], dly [2];
  logic [78:0] txn [2];
  logic [42:0] rsp [2];
  int pv [2][2], sar_p [2], dr_p [2];
  int glog [2][$];
  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask
  function automatic logic [42:0] dpk(int k, int m);
    return {m_d_opcode[k][m], m_d_param[k][m], m_d_size[k][m], m_d_denied[k][m], m_d_data[k][m], m_d_corrupt[k][m]};
  endfunction
  function automatic logic [78:0] sapk(int k);
    return {s_a_opcode[k], s_a_param[k], s_a_size[k], s_a_address[k], s_a_mask[k], s_a_data[k], s_a_corrupt[k]};
  endfunction
  function automatic int winner(int k);
    logic v0, v1;
    v0 = m_a_valid[k][0];
    v1 = m_a_valid[k][1];
    if (!v0 && !v1) return -1;
    if (v0 && v1) return (k == 1) ? 0 : (last_w[k] == 0 ? 1 : 0);
    return v0 ? 0 : 1;
  endfunction
  task automatic step();
    logic [95:0] r;
    int w;
    logic [6:0] e;
    for (int k = 0; k < 2; k++) begin
      for (int m = 0; m < 2; m++) begin
        m_a_valid[k][m] = ($urandom % 100) < pv[k][m];
        r = {$urandom, $urandom, $urandom};
        a_pk[k][m] = r[78:0];
        m_d_ready[k][m] = ($urandom % 100) < dr_p[k];
      end
      s_a_ready[k] = ($urandom % 100) < sar_p[k];
      if (phase[k] == 2 && dly[k] == 0) begin
        s_d_valid[k] = 1'b1;
        d_pk[k] = rsp[k];
      end else begin
        s_d_valid[k] = phase[k] != 2 && ($urandom % 6) == 0;
        r = {$urandom, $urandom, $urandom};
        d_pk[k] = r[42:0];
      end
    end
    #4;
    for (int k = 0; k < 2; k++) begin
      w = (!rst && phase[k] == 0) ? winner(k) : -1;
      e = rst ? 7'd0 : {w == 0, w == 1, phase[k] == 1, phase[k] == 2 && m_d_ready[k][owner[k]],
                        phase[k] == 2 && owner[k] == 0 && s_d_valid[k],
                        phase[k] == 2 && owner[k] == 1 && s_d_valid[k], phase[k] != 0};
      chk($sformatf("ctl%0d", k), {m_a_ready[k][0], m_a_ready[k][1], s_a_valid[k], s_d_ready[k],
          m_d_valid[k][0], m_d_valid[k][1], busy[k]}, e);
      if (rst) chk($sformatf("rst_fields%0d", k), sapk(k), 0);
      else if (phase[k] == 1) chk($sformatf("a_fields%0d", k), sapk(k), txn[k]);
      chk($sformatf("d_fields%0d", k), {dpk(k, 0), dpk(k, 1)}, {d_pk[k], d_pk[k]});
      if (rst) begin
        phase[k] = 0; owner[k] = 0; last_w[k] = 1;
      end else if (w >= 0) begin
        txn[k] = a_pk[k][w]; owner[k] = w; last_w[k] = w; glog[k].push_back(w); phase[k] = 1;
      end else if (phase[k] == 1 && s_a_ready[k]) begin
        phase[k] = 2;
        dly[k] = $urandom % 4;
        r = {$urandom, $urandom, $urandom};
        rsp[k] = r[42:0];
      end else if (phase[k] == 2) begin
        if (dly[k] > 0) dly[k]--;
        else if (s_d_valid[k] && m_d_ready[k][owner[k]]) phase[k] = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic knobs(int p0, int p1, int sa, int dr);
    for (int k = 0; k < 2; k++) begin
      pv[k][0] = p0; pv[k][1] = p1; sar_p[k] = sa; dr_p[k] = dr;
    end
  endtask
  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      phase[k] = 0; owner[k] = 0; last_w[k] = 1; dly[k] = 0;
    end
    knobs(100, 100, 100, 100);
    rst = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    n = 0;
    while ((glog[0].size() < 4 || glog[1].size() < 4) && n < 80) begin
      step();
      n++;
    end
    chk("grant_budget", n < 80, 1);
    for (int j = 0; j < 4; j++) begin
      chk("rr_order", j < glog[0].size() ? glog[0][j] : -1, j % 2);
      chk("prio_order", j < glog[1].size() ? glog[1][j] : -1, 0);
    end
    pv[1][0] = 0;
    glog[1].delete();
    n = 0;
    while (glog[1].size() < 1 && n < 20) begin
      step();
      n++;
    end
    chk("prio_m1_after_drop", glog[1].size() > 0 ? glog[1][0] : -1, 1);
    knobs(100, 0, 0, 100);
    for (int i = 0; i < 8; i++) step();
    knobs(100, 0, 0, 100);
    n = 0;
    while ((phase[0] != 1 || phase[1] != 1) && n < 20) begin
      step();
      n++;
    end
    #2 rst = 1'b1;
    #1 chk("async_rst", {s_a_valid[0], s_a_valid[1], busy[0], busy[1]}, 0);
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    knobs(100, 0, 100, 100);
    glog[0].delete();
    glog[1].delete();
    for (int i = 0; i < 8; i++) step();
    chk("post_rst_grant", {glog[0].size() > 0 ? glog[0][0] : -1, glog[1].size() > 0 ? glog[1][0] : -1}, 0);
    for (int i = 0; i < 1500; i++) begin
      if (i % 50 == 0)
        for (int k = 0; k < 2; k++) begin
          pv[k][0] = $urandom_range(0, 100); pv[k][1] = $urandom_range(0, 100);
          sar_p[k] = $urandom_range(10, 100); dr_p[k] = $urandom_range(10, 100);
        end
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/mmu_tl_arb.md
MMU_TL_ARB -- requirements
Module: mmu_tl_arb

Interface
REQ-001: Parameter HPW_PRIO, default 1, meaning: 1 = fixed priority to m0 (page walker); 0 = round-robin between m0 and m1.
REQ-002: cpu_clk_i  in  1  sole clock; all state updates on rising edge.
REQ-003: cpu_rst_i  in  1  reset, asynchronous, active-high.
REQ-004: m0_a_opcode/param/size/address/mask/data/corrupt  in  3/3/4/32/4/32/1  page-walker TileLink-UL A fields (hpw_a_*).
REQ-005: m0_a_valid  in  1 / m0_a_ready  out  1  page-walker A handshake.
REQ-006: m0_d_opcode/param/size/denied/data/corrupt  out  3/2/4/1/32/1  page-walker D fields.
REQ-007: m0_d_valid  out  1 / m0_d_ready  in  1  page-walker D handshake.
REQ-008: m1_a_* / m1_d_*  same directions and widths as m0  second master (LSU data port).
REQ-009: s_a_opcode/param/size/address/mask/data/corrupt  out  3/3/4/32/4/32/1  merged downstream A fields.
REQ-010: s_a_valid  out  1 / s_a_ready  in  1  downstream A handshake.
REQ-011: s_d_opcode/param/size/denied/data/corrupt  in  3/2/4/1/32/1  downstream D fields.
REQ-012: s_d_valid  in  1 / s_d_ready  out  1  downstream D handshake.
REQ-013: busy_o  out  1  high whenever state is not IDLE.

Function
REQ-014: Only single-beat transactions exist; at most one transaction is outstanding downstream at any time.
REQ-015: States: IDLE, REQ, RESP; owner register (1 bit) records the granted master; last register (1 bit) records the previous grant.
REQ-016: IDLE: if any m*_a_valid, grant combinationally; the granted master alone sees m*_a_ready=1 in that cycle; the non-granted master sees ready=0.
REQ-017: Grant rule, HPW_PRIO=1: m0 wins whenever m0_a_valid=1.
REQ-018: Grant rule, HPW_PRIO=0: single requester wins; both requesting -> master != last wins; last updates at grant.
REQ-019: On grant, A fields of the winner are captured into registers, owner is set, state -> REQ.
REQ-020: REQ: s_a_valid=1 with the registered fields, held stable until s_a_ready=1; then state -> RESP; both m*_a_ready=0.
REQ-021: RESP: s_d_ready = owner's m*_d_ready; owner's m*_d_valid = s_d_valid; non-owner's d_valid=0; D fields are driven combinationally from s_d_* to both masters.
REQ-022: RESP: on s_d_valid && s_d_ready, state -> IDLE; a new grant is possible the following cycle.
REQ-023: Minimum transaction latency: grant cycle + 1 cycle to s_a_valid; throughput at most one transaction per 3 cycles.
REQ-024: s_d_valid arriving while not in RESP is ignored (s_d_ready=0, no master sees d_valid).
REQ-025: s_d_denied and s_d_corrupt are passed through unmodified; no retry, no error generation.
REQ-026: A master dropping a_valid before grant is not an error; no request is latched.
REQ-027: Masters are never interrupted; no flush input; an in-flight transaction always completes.

Reset
REQ-028: While cpu_rst_i=1: state=IDLE, owner=0, last=1, captured A fields=0.
REQ-029: While cpu_rst_i=1: s_a_valid, s_d_ready, m0/m1 a_ready, m0/m1 d_valid, busy_o all 0.
REQ-030: Reset asserted mid-transaction abandons it; after release the block is in IDLE and issues nothing until a new a_valid.

Verification
REQ-031: m0 Get addr 0x8000_1000 size 2, s_a_ready=1, s_d after 2 cycles data 0xDEAD_BEEF -> s_a_valid one cycle after grant with address 0x8000_1000; m0_d_valid with data 0xDEAD_BEEF; m1_d_valid stays 0.
REQ-032: HPW_PRIO=1, m0 and m1 valid every cycle for 4 transactions -> all 4 grants to m0; m1 granted only after m0_a_valid drops.
REQ-033: HPW_PRIO=0, both valid continuously, 4 transactions -> grant order m0, m1, m0, m1.
REQ-034: s_a_ready held 0 for 5 cycles in REQ -> s_a_valid and all captured fields stable for 5 cycles; no m*_a_ready asserted.
REQ-035: m1 in RESP with m1_d_ready=0 for 3 cycles, s_d_valid=1 with denied=1 -> s_d_ready=0 for 3 cycles; handshake on cycle 4; m1 sees denied=1; IDLE next cycle.
REQ-036: cpu_rst_i pulsed during REQ -> s_a_valid drops to 0 immediately (asynchronously); busy_o=0; next m0 request is served normally.
